id_exe_stage: RTL

- ID→EX pipeline register for the 5-stage core; feeds the ALU's op_rs1/op_rs2/exe_imm/exe_dec_info/exe_alu/exe_alui inputs.
- Resolves source operands at capture: bypass from EX (ALU result), MEM and WB, with regfile data as fallback.
- Detects load-use hazards and inserts one bubble; handles branch flush and downstream stall; counts bubbles for performance.

---
 rtl/id_exe_stage_pkg.sv | 33 +++
 rtl/id_exe_stage_if.sv | 74 +++++++
 rtl/id_exe_stage_fwd_mux.sv | 39 +++
 rtl/id_exe_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/id_exe_stage_pkg.sv
//----------------------------------------------------------------------
// id_exe_stage_pkg : shared widths and decode-info bit indices
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package id_exe_stage_pkg;

    localparam int XLEN            = 32;
    localparam int REG_W           = 5;

    localparam int ALU_ADD         = 0;
    localparam int ALU_SUB         = 1;
    localparam int ALU_AND         = 2;
    localparam int ALU_OR          = 3;
    localparam int ALU_XOR         = 4;
    localparam int ALU_SLL         = 5;
    localparam int ALU_SRL         = 6;
    localparam int ALU_SRA         = 7;
    localparam int ALU_SLT         = 8;
    localparam int ALU_SLTU        = 9;
    localparam int DECODE_INFO_LEN = 10;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Producer hit for a source read; x0 never matches so it always reads 0.
    function automatic logic src_hit(input logic en, input reg_idx_t rd, input reg_idx_t rs);
        return en && (rd == rs) && (rs != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_exe_stage_if.sv
//----------------------------------------------------------------------
// id_exe_stage_if : ID inputs, bypass sources and EX-side register outputs
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface id_exe_stage_if
    import id_exe_stage_pkg::*;
#(
    parameter int DEC_W = DECODE_INFO_LEN,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    reg_idx_t         id_rs1_addr;
    reg_idx_t         id_rs2_addr;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [DEC_W-1:0] id_dec_info;
    logic             id_alu;
    logic             id_alui;
    logic             id_load;
    reg_idx_t         id_rd_addr;
    logic             id_rd_wen;
    logic [XLEN-1:0]  alu_result;
    logic             mem_valid;
    logic             mem_rd_wen;
    reg_idx_t         mem_rd_addr;
    logic [XLEN-1:0]  mem_result;
    logic             wb_valid;
    logic             wb_rd_wen;
    reg_idx_t         wb_rd_addr;
    logic [XLEN-1:0]  wb_result;
    logic             flush;
    logic             exe_stall;
    logic             exe_valid;
    logic [XLEN-1:0]  exe_pc;
    logic [XLEN-1:0]  op_rs1;
    logic [XLEN-1:0]  op_rs2;
    logic [XLEN-1:0]  exe_imm;
    logic [DEC_W-1:0] exe_dec_info;
    logic             exe_alu;
    logic             exe_alui;
    logic             exe_load;
    logic             exe_rd_wen;
    reg_idx_t         exe_rd_addr;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rs1_data, id_rs2_data, id_imm, id_dec_info, id_alu, id_alui, id_load,
               id_rd_addr, id_rd_wen, alu_result, mem_valid, mem_rd_wen, mem_rd_addr,
               mem_result, wb_valid, wb_rd_wen, wb_rd_addr, wb_result, flush, exe_stall,
        input  id_ready, exe_valid, exe_pc, op_rs1, op_rs2, exe_imm, exe_dec_info,
               exe_alu, exe_alui, exe_load, exe_rd_wen, exe_rd_addr, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rs1_data, id_rs2_data, id_imm, id_dec_info, id_alu, id_alui, id_load,
               id_rd_addr, id_rd_wen, alu_result, mem_valid, mem_rd_wen, mem_rd_addr,
               mem_result, wb_valid, wb_rd_wen, wb_rd_addr, wb_result, flush, exe_stall,
        output id_ready, exe_valid, exe_pc, op_rs1, op_rs2, exe_imm, exe_dec_info,
               exe_alu, exe_alui, exe_load, exe_rd_wen, exe_rd_addr, bubble_cnt
    );

endinterface

`default_nettype wire

// File: rtl/id_exe_stage_fwd_mux.sv
//----------------------------------------------------------------------
// fwd_mux : priority operand bypass EX > MEM > WB > regfile
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module fwd_mux
    import id_exe_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  reg_idx_t        rs_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_en,
    input  reg_idx_t        ex_rd_addr,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_en,
    input  reg_idx_t        mem_rd_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_en,
    input  reg_idx_t        wb_rd_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (src_hit(ex_en, ex_rd_addr, rs_addr)) begin
            operand = ex_data;
        end else if (src_hit(mem_en, mem_rd_addr, rs_addr)) begin
            operand = mem_data;
        end else if (src_hit(wb_en, wb_rd_addr, rs_addr)) begin
            operand = wb_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_exe_stage.sv
//----------------------------------------------------------------------
// id_exe_stage : ID->EX pipeline register with bypass, load-use bubble
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int DEC_W = DECODE_INFO_LEN,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    id_exe_stage_if.slave bus
);

    logic             r_exe_valid;
    logic [XLEN-1:0]  r_exe_pc;
    logic [XLEN-1:0]  r_op_rs1;
    logic [XLEN-1:0]  r_op_rs2;
    logic [XLEN-1:0]  r_exe_imm;
    logic [DEC_W-1:0] r_exe_dec_info;
    logic             r_exe_alu;
    logic             r_exe_alui;
    logic             r_exe_load;
    logic             r_exe_rd_wen;
    reg_idx_t         r_exe_rd_addr;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic             w_hz;
    logic             w_ex_fwd_en;
    logic             w_mem_fwd_en;
    logic             w_wb_fwd_en;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    assign w_hz = r_exe_valid && r_exe_load && r_exe_rd_wen && (r_exe_rd_addr != '0) &&
                  ((bus.id_rs1_used && (bus.id_rs1_addr == r_exe_rd_addr)) ||
                   (bus.id_rs2_used && (bus.id_rs2_addr == r_exe_rd_addr)));

    assign bus.id_ready = bus.flush || (!bus.exe_stall && !w_hz);

    // Load data is not yet available in EX, so a load never bypasses from there.
    assign w_ex_fwd_en  = r_exe_valid && r_exe_rd_wen && !r_exe_load;
    assign w_mem_fwd_en = bus.mem_valid && bus.mem_rd_wen;
    assign w_wb_fwd_en  = bus.wb_valid && bus.wb_rd_wen;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr     (bus.id_rs1_addr),
        .rf_data     (bus.id_rs1_data),
        .ex_en       (w_ex_fwd_en),
        .ex_rd_addr  (r_exe_rd_addr),
        .ex_data     (bus.alu_result),
        .mem_en      (w_mem_fwd_en),
        .mem_rd_addr (bus.mem_rd_addr),
        .mem_data    (bus.mem_result),
        .wb_en       (w_wb_fwd_en),
        .wb_rd_addr  (bus.wb_rd_addr),
        .wb_data     (bus.wb_result),
        .operand     (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr     (bus.id_rs2_addr),
        .rf_data     (bus.id_rs2_data),
        .ex_en       (w_ex_fwd_en),
        .ex_rd_addr  (r_exe_rd_addr),
        .ex_data     (bus.alu_result),
        .mem_en      (w_mem_fwd_en),
        .mem_rd_addr (bus.mem_rd_addr),
        .mem_data    (bus.mem_result),
        .wb_en       (w_wb_fwd_en),
        .wb_rd_addr  (bus.wb_rd_addr),
        .wb_data     (bus.wb_result),
        .operand     (w_fwd_rs2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exe_valid    <= 1'b0;
            r_exe_pc       <= '0;
            r_op_rs1       <= '0;
            r_op_rs2       <= '0;
            r_exe_imm      <= '0;
            r_exe_dec_info <= '0;
            r_exe_alu      <= 1'b0;
            r_exe_alui     <= 1'b0;
            r_exe_load     <= 1'b0;
            r_exe_rd_wen   <= 1'b0;
            r_exe_rd_addr  <= '0;
            r_bubble_cnt   <= '0;
        end else if (bus.flush || (!bus.exe_stall && (w_hz || !bus.id_valid))) begin
            // Every non-capturing, non-holding case leaves a bubble with zeroed control.
            r_exe_valid    <= 1'b0;
            r_exe_dec_info <= '0;
            r_exe_alu      <= 1'b0;
            r_exe_alui     <= 1'b0;
            r_exe_load     <= 1'b0;
            r_exe_rd_wen   <= 1'b0;
            if (!bus.flush && w_hz && bus.id_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (!bus.exe_stall) begin
            r_exe_valid    <= 1'b1;
            r_exe_pc       <= bus.id_pc;
            r_op_rs1       <= w_fwd_rs1;
            r_op_rs2       <= w_fwd_rs2;
            r_exe_imm      <= bus.id_imm;
            r_exe_dec_info <= bus.id_dec_info;
            r_exe_alu      <= bus.id_alu;
            r_exe_alui     <= bus.id_alui;
            r_exe_load     <= bus.id_load;
            r_exe_rd_wen   <= bus.id_rd_wen;
            r_exe_rd_addr  <= bus.id_rd_addr;
        end
    end

    assign bus.exe_valid    = r_exe_valid;
    assign bus.exe_pc       = r_exe_pc;
    assign bus.op_rs1       = r_op_rs1;
    assign bus.op_rs2       = r_op_rs2;
    assign bus.exe_imm      = r_exe_imm;
    assign bus.exe_dec_info = r_exe_dec_info;
    assign bus.exe_alu      = r_exe_alu;
    assign bus.exe_alui     = r_exe_alui;
    assign bus.exe_load     = r_exe_load;
    assign bus.exe_rd_wen   = r_exe_rd_wen;
    assign bus.exe_rd_addr  = r_exe_rd_addr;
    assign bus.bubble_cnt   = r_bubble_cnt;

endmodule

`default_nettype wire
